// File: rtl/decode_branch_sched_pkg.sv
// Shared types and constants for the decode-stage branch scheduler.
package decode_branch_sched_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int INSTR_WIDTH    = 32;
    localparam int GPR_NUM        = 32;
    localparam int REG_ADDR_WIDTH = $clog2(GPR_NUM);
    localparam int ALU_OP_WIDTH   = 8;
    localparam int ALU_SEL_WIDTH  = 3;

    // Result-select code the decoder uses for jump/branch class operations.
    localparam logic [ALU_SEL_WIDTH-1:0] EXE_RES_JUMP = 3'b101;

    // One instruction buffer entry.
    typedef struct packed {
        logic [DATA_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } instr_buffer_info_t;

    // Decoded operation handed to dispatch.
    typedef struct packed {
        logic [DATA_WIDTH-1:0]       pc;
        logic [INSTR_WIDTH-1:0]      instr;
        logic [ALU_OP_WIDTH-1:0]     aluop;
        logic [ALU_SEL_WIDTH-1:0]    alusel;
        logic [DATA_WIDTH-1:0]       imm;
        logic [1:0]                  rrv;
        logic [2*REG_ADDR_WIDTH-1:0] rra;
        logic                        rwv;
        logic [REG_ADDR_WIDTH-1:0]   rwa;
        logic                        ine;
    } decode_op_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } sched_state_e;

    // Width of a counter able to hold 0..max_br.
    function automatic int br_cnt_width(input int max_br);
        return $clog2(max_br + 1);
    endfunction

endpackage

// File: rtl/decode_branch_sched_if.sv
// Bundle of buffer, decoder, dispatch and branch-resolve signals around the
// decode-stage scheduler. "slave" is the scheduler side, "master" the
// surrounding pipeline.
interface decode_branch_sched_if #(
    parameter int MAX_BR = 2
);
    import decode_branch_sched_pkg::*;

    localparam int CNT_W = br_cnt_width(MAX_BR);

    logic                               flush_i;
    logic                               in_valid_i;
    instr_buffer_info_t                 in_instr_i;
    logic                               in_ready_o;
    instr_buffer_info_t                 dec_instr_o;
    logic                               dec_valid_i;
    logic [ALU_OP_WIDTH-1:0]            dec_aluop_i;
    logic [ALU_SEL_WIDTH-1:0]           dec_alusel_i;
    logic [DATA_WIDTH-1:0]              dec_imm_i;
    logic [1:0]                         dec_rrv_i;
    logic [2*REG_ADDR_WIDTH-1:0]        dec_rra_i;
    logic                               dec_rwv_i;
    logic [REG_ADDR_WIDTH-1:0]          dec_rwa_i;
    logic                               out_valid_o;
    logic                               out_ready_i;
    decode_op_t                         out_op_o;
    logic                               br_resolve_i;
    logic [CNT_W-1:0]                   br_cnt_o;
    logic [31:0]                        stall_cnt_o;

    modport slave (
        input  flush_i, in_valid_i, in_instr_i,
        input  dec_valid_i, dec_aluop_i, dec_alusel_i, dec_imm_i,
        input  dec_rrv_i, dec_rra_i, dec_rwv_i, dec_rwa_i,
        input  out_ready_i, br_resolve_i,
        output in_ready_o, dec_instr_o, out_valid_o, out_op_o,
        output br_cnt_o, stall_cnt_o
    );

    modport master (
        output flush_i, in_valid_i, in_instr_i,
        output dec_valid_i, dec_aluop_i, dec_alusel_i, dec_imm_i,
        output dec_rrv_i, dec_rra_i, dec_rwv_i, dec_rwa_i,
        output out_ready_i, br_resolve_i,
        input  in_ready_o, dec_instr_o, out_valid_o, out_op_o,
        input  br_cnt_o, stall_cnt_o
    );

endinterface

// File: rtl/decode_branch_sched_br_inflight_ctr.sv
// Up/down counter of unresolved jump-class operations, saturating at 0 and
// MAX_BR, with a "room for one more" compare against the limit.
module br_inflight_ctr #(
    parameter  int MAX_BR = 2,
    localparam int CNT_W  = $clog2(MAX_BR + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             below_max
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_BR);

    logic [CNT_W-1:0] cnt_q;

    assign cnt       = cnt_q;
    assign below_max = (cnt_q < LIMIT);

    // Clear dominates; a simultaneous issue and resolve cancel out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !dec) begin
            if (cnt_q != LIMIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/decode_branch_sched.sv
// Decode-stage sequencer for the branch/jump path: one-entry stage register,
// pass-through of the external decoder result to dispatch, and a limit on
// unresolved jump-class operations with a stall state and stall counter.
module decode_branch_sched
    import decode_branch_sched_pkg::*;
#(
    parameter int MAX_BR = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    decode_branch_sched_if.slave  bus
);

    localparam int CNT_W = br_cnt_width(MAX_BR);

    sched_state_e       state;
    logic               hold_v;
    instr_buffer_info_t hold_instr;
    logic [31:0]        stall_cnt;

    logic               is_br;
    logic               can_issue;
    logic               below_max;
    logic [CNT_W-1:0]   br_cnt;
    logic               out_valid;
    logic               fire;
    logic               in_ready;
    logic               accept;
    instr_buffer_info_t dec_instr;
    decode_op_t         op;

    // Invalid decodes never count as jump-class even if alusel happens to match.
    assign is_br     = bus.dec_valid_i && (bus.dec_alusel_i == EXE_RES_JUMP);
    // A resolve in the same cycle frees a slot, so the branch may go at the limit.
    assign can_issue = !is_br || below_max || bus.br_resolve_i;

    assign out_valid = hold_v && can_issue && (state == RUN) && !bus.flush_i;
    assign fire      = out_valid && bus.out_ready_i;
    assign in_ready  = (state == RUN) && !bus.flush_i && (!hold_v || fire);
    assign accept    = bus.in_valid_i && in_ready;

    assign dec_instr = hold_v ? hold_instr : '0;

    // Decoded op is the held entry merged with the decoder's combinational result.
    always_comb begin
        op        = '0;
        op.pc     = dec_instr.pc;
        op.instr  = dec_instr.instr;
        op.aluop  = bus.dec_aluop_i;
        op.alusel = bus.dec_alusel_i;
        op.imm    = bus.dec_imm_i;
        op.rrv    = bus.dec_rrv_i;
        op.rra    = bus.dec_rra_i;
        op.rwv    = bus.dec_rwv_i;
        op.rwa    = bus.dec_rwa_i;
        op.ine    = !bus.dec_valid_i;
    end

    assign bus.dec_instr_o = dec_instr;
    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.out_op_o    = op;
    assign bus.br_cnt_o    = br_cnt;
    assign bus.stall_cnt_o = stall_cnt;

    br_inflight_ctr #(
        .MAX_BR    (MAX_BR)
    ) u_br_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (bus.flush_i),
        .inc       (fire && is_br),
        .dec       (bus.br_resolve_i),
        .cnt       (br_cnt),
        .below_max (below_max)
    );

    // Instruction payload is data only; its validity lives in hold_v.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_instr <= bus.in_instr_i;
        end
    end

    // Control FSM: stage occupancy, branch-limit stall, flush recovery, stall count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            hold_v    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if ((state == BR_WAIT) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (bus.flush_i) begin
                state  <= FLUSH;
                hold_v <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (accept) begin
                            hold_v <= 1'b1;
                        end else if (fire) begin
                            hold_v <= 1'b0;
                        end
                        if (hold_v && is_br && !can_issue) begin
                            state <= BR_WAIT;
                        end
                    end
                    BR_WAIT: begin
                        // Issue resumes the cycle after the resolve lands.
                        if (bus.br_resolve_i) begin
                            state <= RUN;
                        end
                    end
                    FLUSH: begin
                        state <= RUN;
                    end
                    default: begin
                        state <= RUN;
                    end
                endcase
            end
        end
    end

endmodule
